// File: rtl/new_means_calc.sv
// new_means_calc: computes the new mean of each of the 8 centroids after an
// accumulation pass by dividing every per-coordinate accumulator by the
// centroid's point count, then writes the centroids back one at a time.
// A single restoring divider (one quotient bit per cycle, MSB first) is
// shared across all centroids and coordinates. Centroids with a zero count
// are skipped so the classification block keeps its old value.
module new_means_calc #(
    parameter int dataWidth        = 91,
    parameter int accum_width      = 154,
    parameter int accum_cord_width = 22,
    parameter int cordinate_width  = 13,
    parameter int count_width      = 10,
    parameter int centroid_num     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [accum_width-1:0]    accum_1,
    input  logic [accum_width-1:0]    accum_2,
    input  logic [accum_width-1:0]    accum_3,
    input  logic [accum_width-1:0]    accum_4,
    input  logic [accum_width-1:0]    accum_5,
    input  logic [accum_width-1:0]    accum_6,
    input  logic [accum_width-1:0]    accum_7,
    input  logic [accum_width-1:0]    accum_8,
    input  logic [count_width-1:0]    cnt_1,
    input  logic [count_width-1:0]    cnt_2,
    input  logic [count_width-1:0]    cnt_3,
    input  logic [count_width-1:0]    cnt_4,
    input  logic [count_width-1:0]    cnt_5,
    input  logic [count_width-1:0]    cnt_6,
    input  logic [count_width-1:0]    cnt_7,
    input  logic [count_width-1:0]    cnt_8,
    output logic                      busy,
    output logic [dataWidth-1:0]      new_centroid,
    output logic [centroid_num-1:0]   centroid_en,
    output logic                      done
);

    localparam int coord_num = dataWidth / cordinate_width;
    localparam int bit_w     = $clog2(accum_cord_width);
    localparam int j_w       = $clog2(coord_num);
    localparam int k_w       = $clog2(centroid_num);
    localparam int idx_w     = $clog2(accum_width);
    localparam int rem_w     = count_width + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        DIV  = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_next;

    logic [k_w-1:0]                k_idx;
    logic [j_w-1:0]                j_idx;
    logic [bit_w-1:0]              bit_cnt;
    logic [rem_w-1:0]              rem;
    logic [accum_cord_width-2:0]   quo;

    logic [accum_width-1:0]        accum_sel;
    logic [count_width-1:0]        cnt_sel;
    logic [idx_w-1:0]              bit_idx;
    logic                          dividend_bit;
    logic [rem_w:0]                rem_shift;
    logic [rem_w:0]                rem_trial;
    logic                          quo_bit;
    logic [rem_w-1:0]              rem_next;
    logic [accum_cord_width-1:0]   quo_full;
    logic [cordinate_width-1:0]    quo_sat;

    logic last_bit;
    logic last_coord;
    logic last_centroid;

    assign last_bit      = (bit_cnt == bit_w'(accum_cord_width - 1));
    assign last_coord    = (j_idx == j_w'(coord_num - 1));
    assign last_centroid = (k_idx == k_w'(centroid_num - 1));

    // Select the accumulator and count of the centroid currently being processed.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        accum_sel = accum_1;
        cnt_sel   = cnt_1;
        case (k_idx)
            3'd1: begin accum_sel = accum_2; cnt_sel = cnt_2; end
            3'd2: begin accum_sel = accum_3; cnt_sel = cnt_3; end
            3'd3: begin accum_sel = accum_4; cnt_sel = cnt_4; end
            3'd4: begin accum_sel = accum_5; cnt_sel = cnt_5; end
            3'd5: begin accum_sel = accum_6; cnt_sel = cnt_6; end
            3'd6: begin accum_sel = accum_7; cnt_sel = cnt_7; end
            3'd7: begin accum_sel = accum_8; cnt_sel = cnt_8; end
            default: begin accum_sel = accum_1; cnt_sel = cnt_1; end
        endcase
    end

    // One restoring-divide step: the dividend bit is read straight from the
    // held accumulator input (MSB first), so no dividend copy is kept.
    always_comb begin
        bit_idx      = idx_w'(int'(j_idx) * accum_cord_width
                              + (accum_cord_width - 1) - int'(bit_cnt));
        dividend_bit = accum_sel[bit_idx];
        rem_shift    = {rem, dividend_bit};
        rem_trial    = rem_shift - {2'b00, cnt_sel};
        quo_bit      = (rem_shift >= {2'b00, cnt_sel});
        rem_next     = quo_bit ? rem_trial[rem_w-1:0] : rem_shift[rem_w-1:0];
        quo_full     = {quo, quo_bit};
        quo_sat      = (|quo_full[accum_cord_width-1:cordinate_width])
                       ? {cordinate_width{1'b1}}
                       : quo_full[cordinate_width-1:0];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every register samples pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        centroid_en = '0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                busy = 1'b1;
                if (cnt_sel == '0) state_next = last_centroid ? DONE : LOAD;
                else               state_next = DIV;
            end
            DIV: begin
                busy = 1'b1;
                if (last_bit && last_coord) state_next = EMIT;
            end
            EMIT: begin
                busy        = 1'b1;
                centroid_en = centroid_num'(1) << k_idx;
                state_next  = last_centroid ? DONE : LOAD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Indices, divider registers and the new_centroid holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_idx        <= '0;
            j_idx        <= '0;
            bit_cnt      <= '0;
            rem          <= '0;
            quo          <= '0;
            new_centroid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) k_idx <= '0;
                end
                LOAD: begin
                    j_idx   <= '0;
                    bit_cnt <= '0;
                    rem     <= '0;
                    quo     <= '0;
                    if (cnt_sel == '0 && !last_centroid) k_idx <= k_idx + 1'b1;
                end
                DIV: begin
                    if (last_bit) begin
                        for (int c = 0; c < coord_num; c++) begin
                            if (j_w'(c) == j_idx)
                                new_centroid[c*cordinate_width +: cordinate_width] <= quo_sat;
                        end
                        bit_cnt <= '0;
                        rem     <= '0;
                        quo     <= '0;
                        if (!last_coord) j_idx <= j_idx + 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        rem     <= rem_next;
                        quo     <= {quo[accum_cord_width-3:0], quo_bit};
                    end
                end
                EMIT: begin
                    if (!last_centroid) k_idx <= k_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
